// File: rtl/hive_mem_arb.sv
// hive_mem_arb: main-memory data port arbiter.
//
// Picks at most one of REQ_N requesters per clock with a round-robin grant.
// A requester can hold the grant for a read-modify-write sequence by raising
// its lock bit. The hold lasts at most LOCK_MAX consecutive grants. Each read
// is tagged with the issuing requester's id. The tag is returned together
// with the memory read word RD_LAT+1 clocks after the accepting edge.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   rq_vld_i / rq_rdy_o   per-requester request valid / accepted this cycle
//   rq_wr_i, rq_byt_i,    per-requester access kind: write, byte, halfword,
//   rq_hlf_i, rq_sgn_i    sign-extended read
//   rq_lock_i             per-requester hold-grant request
//   rq_addr_i, rq_data_i  packed per-requester byte address / write data
//   rd_vld_o, rd_id_o,    read return strobe, owning requester, data
//   rd_data_o
//   mem_*_o               registered command to the memory data port
//   mem_rd_i              memory read data (passed straight to rd_data_o)
module hive_mem_arb #(
  parameter int REQ_N      = 4,
  parameter int MEM_ADDR_W = 16,
  parameter int ALU_W      = 32,
  parameter int RD_LAT     = 4,
  parameter int LOCK_MAX   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [REQ_N-1:0]            rq_vld_i,
  output logic [REQ_N-1:0]            rq_rdy_o,
  input  logic [REQ_N-1:0]            rq_wr_i,
  input  logic [REQ_N-1:0]            rq_byt_i,
  input  logic [REQ_N-1:0]            rq_hlf_i,
  input  logic [REQ_N-1:0]            rq_sgn_i,
  input  logic [REQ_N-1:0]            rq_lock_i,
  input  logic [REQ_N*MEM_ADDR_W-1:0] rq_addr_i,
  input  logic [REQ_N*ALU_W-1:0]      rq_data_i,
  output logic                        rd_vld_o,
  output logic [$clog2(REQ_N)-1:0]    rd_id_o,
  output logic [ALU_W-1:0]            rd_data_o,
  output logic                        mem_wr_o,
  output logic                        mem_byt_o,
  output logic                        mem_hlf_o,
  output logic                        mem_sgn_o,
  output logic [MEM_ADDR_W-1:0]       mem_addr_o,
  output logic [ALU_W-1:0]            mem_data_o,
  input  logic [ALU_W-1:0]            mem_rd_i
);

  localparam int ID_W  = $clog2(REQ_N);
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  typedef enum logic {LK_IDLE, LK_LOCKED} lk_state_t;

  lk_state_t                       lk_state_reg;
  logic [ID_W-1:0]                 lk_owner_reg;
  logic [CNT_W-1:0]                lk_cnt_reg;
  logic [ID_W-1:0]                 rr_ptr_reg;
  logic [ID_W-1:0]                 rr_next;

  logic [REQ_N-1:0][MEM_ADDR_W-1:0] rq_addr_arr;
  logic [REQ_N-1:0][ALU_W-1:0]      rq_data_arr;
  logic [REQ_N-1:0][ID_W-1:0]       cand_id;

  logic                            lock_hold;
  logic                            grant_vld;
  logic [ID_W-1:0]                 grant_id;
  logic                            accept;

  logic [RD_LAT:0]                 tag_vld_reg;
  logic [RD_LAT:0][ID_W-1:0]       tag_id_reg;

  // The packed 2-D views have the same bit layout as the flat input buses.
  assign rq_addr_arr = rq_addr_i;
  assign rq_data_arr = rq_data_i;

  // cand_id[k] is the requester at search position k, counting from the
  // round-robin pointer and wrapping modulo REQ_N.
  genvar gi;
  generate
    for (gi = 0; gi < REQ_N; gi++) begin : g_cand
      logic [ID_W:0] sum;
      assign sum = {1'b0, rr_ptr_reg} + (ID_W+1)'(gi);
      assign cand_id[gi] = (sum >= (ID_W+1)'(REQ_N)) ?
                           ID_W'(sum - (ID_W+1)'(REQ_N)) : sum[ID_W-1:0];
    end
  endgenerate

  // A held lock is effective only while the owner keeps its lock bit up.
  // Dropping the bit releases the port in the same cycle. The lock is
  // honoured even when the owner is idle, so the other requesters see rdy=0.
  assign lock_hold = (lk_state_reg == LK_LOCKED) && rq_lock_i[lk_owner_reg];

  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    if (lock_hold) begin
      grant_vld = rq_vld_i[lk_owner_reg];
      grant_id  = lk_owner_reg;
    end else begin
      // Walk the positions from last to first so the first valid one wins.
      for (int k = REQ_N - 1; k >= 0; k--) begin
        if (rq_vld_i[cand_id[k]]) begin
          grant_vld = 1'b1;
          grant_id  = cand_id[k];
        end
      end
    end
  end

  assign accept   = grant_vld & ~rst_i;
  assign rq_rdy_o = accept ? (REQ_N'(1) << grant_id) : '0;
  assign rr_next  = (grant_id == ID_W'(REQ_N - 1)) ? '0 : grant_id + 1'b1;

  // rd_data_o is a combinational pass-through of the memory read data.
  assign rd_data_o = mem_rd_i;

  // The command register and the round-robin pointer are updated on every
  // accepting edge. When no request is accepted, mem_wr_o is cleared and
  // the other fields hold, so the memory sees a harmless repeated read.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_reg <= '0;
      mem_wr_o   <= 1'b0;
      mem_byt_o  <= 1'b0;
      mem_hlf_o  <= 1'b0;
      mem_sgn_o  <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else if (accept) begin
      rr_ptr_reg <= rr_next;
      mem_wr_o   <= rq_wr_i[grant_id];
      mem_byt_o  <= rq_byt_i[grant_id];
      mem_hlf_o  <= rq_hlf_i[grant_id];
      mem_sgn_o  <= rq_sgn_i[grant_id];
      mem_addr_o <= rq_addr_arr[grant_id];
      mem_data_o <= rq_data_arr[grant_id];
    end else begin
      mem_wr_o   <= 1'b0;
    end
  end

  // Lock FSM. A forced release after LOCK_MAX grants returns to IDLE on the
  // accepting edge. The owner cannot re-lock on that edge. The pointer has
  // already moved to owner+1, so the other requesters get the next turn.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lk_state_reg <= LK_IDLE;
      lk_owner_reg <= '0;
      lk_cnt_reg   <= '0;
    end else if (lock_hold) begin
      if (accept) begin
        if (lk_cnt_reg == CNT_W'(LOCK_MAX - 1)) begin
          lk_state_reg <= LK_IDLE;
          lk_cnt_reg   <= '0;
        end else begin
          lk_cnt_reg   <= lk_cnt_reg + 1'b1;
        end
      end
    end else if (accept && rq_lock_i[grant_id] && (LOCK_MAX > 1)) begin
      lk_state_reg <= LK_LOCKED;
      lk_owner_reg <= grant_id;
      lk_cnt_reg   <= CNT_W'(1);
    end else begin
      lk_state_reg <= LK_IDLE;
      lk_cnt_reg   <= '0;
    end
  end

  // Read tag pipe. Stage 0 is loaded on the accepting edge and reaches the
  // last stage RD_LAT edges later. The return registers add one more edge,
  // which lines rd_vld_o up with the memory's command sample plus RD_LAT.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tag_vld_reg <= '0;
      tag_id_reg  <= '0;
      rd_vld_o    <= 1'b0;
      rd_id_o     <= '0;
    end else begin
      tag_vld_reg <= {tag_vld_reg[RD_LAT-1:0], accept & ~rq_wr_i[grant_id]};
      tag_id_reg  <= {tag_id_reg[RD_LAT-1:0], grant_id};
      rd_vld_o    <= tag_vld_reg[RD_LAT];
      rd_id_o     <= tag_id_reg[RD_LAT];
    end
  end

endmodule

// File: tb/tb_hive_mem_arb.sv
// tb_hive_mem_arb: directed bench for hive_mem_arb.
//
// Includes a small byte-addressed memory model. The model samples the
// command registers on each clock edge and presents read data RD_LAT edges
// after the sample. Inputs are driven on the falling edge. Combinational
// grants are checked 1 ns later, and registered outputs are checked on the
// falling edge.
module tb_hive_mem_arb;
  localparam int REQ_N      = 4;
  localparam int MEM_ADDR_W = 16;
  localparam int ALU_W      = 32;
  localparam int RD_LAT     = 4;
  localparam int LOCK_MAX   = 16;

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic [REQ_N-1:0]            rq_vld_i, rq_rdy_o, rq_wr_i, rq_byt_i;
  logic [REQ_N-1:0]            rq_hlf_i, rq_sgn_i, rq_lock_i;
  logic [REQ_N*MEM_ADDR_W-1:0] rq_addr_i;
  logic [REQ_N*ALU_W-1:0]      rq_data_i;
  logic                        rd_vld_o;
  logic [$clog2(REQ_N)-1:0]    rd_id_o;
  logic [ALU_W-1:0]            rd_data_o;
  logic                        mem_wr_o, mem_byt_o, mem_hlf_o, mem_sgn_o;
  logic [MEM_ADDR_W-1:0]       mem_addr_o;
  logic [ALU_W-1:0]            mem_data_o;
  logic [ALU_W-1:0]            mem_rd_i;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk_i = ~clk_i;

  hive_mem_arb #(
    .REQ_N(REQ_N), .MEM_ADDR_W(MEM_ADDR_W), .ALU_W(ALU_W),
    .RD_LAT(RD_LAT), .LOCK_MAX(LOCK_MAX)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .rq_vld_i(rq_vld_i), .rq_rdy_o(rq_rdy_o), .rq_wr_i(rq_wr_i),
    .rq_byt_i(rq_byt_i), .rq_hlf_i(rq_hlf_i), .rq_sgn_i(rq_sgn_i),
    .rq_lock_i(rq_lock_i), .rq_addr_i(rq_addr_i), .rq_data_i(rq_data_i),
    .rd_vld_o(rd_vld_o), .rd_id_o(rd_id_o), .rd_data_o(rd_data_o),
    .mem_wr_o(mem_wr_o), .mem_byt_o(mem_byt_o), .mem_hlf_o(mem_hlf_o),
    .mem_sgn_o(mem_sgn_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_rd_i(mem_rd_i)
  );

  // Memory model: little-endian bytes, 256-byte window.
  logic [7:0]       mem_b [0:255];
  logic [ALU_W-1:0] hist  [0:RD_LAT];
  assign mem_rd_i = hist[RD_LAT];

  function automatic logic [31:0] mem_read();
    logic [7:0] a;
    a = mem_addr_o[7:0];
    if (mem_byt_o)
      return mem_sgn_o ? {{24{mem_b[a][7]}}, mem_b[a]} : {24'b0, mem_b[a]};
    else if (mem_hlf_o)
      return mem_sgn_o ? {{16{mem_b[a+8'd1][7]}}, mem_b[a+8'd1], mem_b[a]}
                       : {16'b0, mem_b[a+8'd1], mem_b[a]};
    else
      return {mem_b[a+8'd3], mem_b[a+8'd2], mem_b[a+8'd1], mem_b[a]};
  endfunction

  always @(posedge clk_i) begin
    if (mem_wr_o) begin
      mem_b[mem_addr_o[7:0]] <= mem_data_o[7:0];
      if (!mem_byt_o) mem_b[mem_addr_o[7:0]+8'd1] <= mem_data_o[15:8];
      if (!mem_byt_o && !mem_hlf_o) begin
        mem_b[mem_addr_o[7:0]+8'd2] <= mem_data_o[23:16];
        mem_b[mem_addr_o[7:0]+8'd3] <= mem_data_o[31:24];
      end
    end
    hist[0] <= mem_read();
    for (int i = 1; i <= RD_LAT; i++) hist[i] <= hist[i-1];
  end

  // One line per transaction: each accept and each read return.
  always @(posedge clk_i) begin
    for (int n = 0; n < REQ_N; n++)
      if (!rst_i && rq_vld_i[n] && rq_rdy_o[n])
        $display("%0t accept port=%0d wr=%0d addr=%h", $time, n, rq_wr_i[n],
                 rq_addr_i[n*MEM_ADDR_W +: MEM_ADDR_W]);
  end
  always @(negedge clk_i) begin
    if (rd_vld_o) $display("%0t return id=%0d data=%h", $time, rd_id_o, rd_data_o);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_port(input int n, input logic wr, input logic byt, input logic sgn,
                          input logic [15:0] a, input logic [31:0] d);
    rq_wr_i[n]  = wr;
    rq_byt_i[n] = byt;
    rq_hlf_i[n] = 1'b0;
    rq_sgn_i[n] = sgn;
    rq_addr_i[n*MEM_ADDR_W +: MEM_ADDR_W] = a;
    rq_data_i[n*ALU_W +: ALU_W] = d;
  endtask

  task automatic do_reset();
    rq_vld_i  = '0;
    rq_lock_i = '0;
    rst_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rr_exp  [8];
    logic [3:0] rr_vld  [8];
    logic [3:0] post_lk [4];
    logic       exp_rv;

    rst_i = 1'b1;
    rq_vld_i = '0; rq_wr_i = '0; rq_byt_i = '0; rq_hlf_i = '0;
    rq_sgn_i = '0; rq_lock_i = '0; rq_addr_i = '0; rq_data_i = '0;

    // Reset with port 1 read pending, then first accept and its return.
    set_port(1, 1'b0, 1'b0, 1'b0, 16'h0010, 32'h0);
    rq_vld_i = 4'b0010;
    repeat (3) @(negedge clk_i);
    #1;
    check("rst_rdy", rq_rdy_o, 4'b0000);
    check("rst_mem_addr", mem_addr_o, 16'h0000);
    check("rst_mem_wr", mem_wr_o, 1'b0);
    check("rst_rd_vld", rd_vld_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    #1 check("t1_rdy", rq_rdy_o, 4'b0010);
    @(negedge clk_i);
    check("t1_mem_addr", mem_addr_o, 16'h0010);
    rq_vld_i = '0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_i);
      check("t1_rd_vld", rd_vld_o, i == 5);
      if (i == 5) check("t1_rd_id", rd_id_o, 2'd1);
    end

    // Round robin with all ports valid, then port 2 idle for one cycle.
    do_reset();
    for (int n = 0; n < REQ_N; n++) set_port(n, 1'b0, 1'b0, 1'b0, 16'h0040 + 16'(n*4), 32'h0);
    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001};
    rr_vld = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'b1011, 4'hF};
    for (int c = 0; c < 8; c++) begin
      rq_vld_i = rr_vld[c];
      #1 check("rr_grant", rq_rdy_o, rr_exp[c]);
      @(negedge clk_i);
    end

    // Back-to-back write, word read, signed byte read.
    do_reset();
    set_port(0, 1'b1, 1'b0, 1'b0, 16'h0020, 32'hDEADBEEF);
    rq_vld_i = 4'b0001;
    #1 check("b2b_wr_rdy", rq_rdy_o, 4'b0001);
    @(negedge clk_i);
    check("b2b_mem_wr", mem_wr_o, 1'b1);
    check("b2b_mem_addr", mem_addr_o, 16'h0020);
    check("b2b_mem_data", mem_data_o, 32'hDEADBEEF);
    set_port(0, 1'b0, 1'b0, 1'b0, 16'h0020, 32'h0);
    #1 check("b2b_rd_rdy", rq_rdy_o, 4'b0001);
    @(negedge clk_i);
    check("b2b_mem_wr_rd", mem_wr_o, 1'b0);
    set_port(0, 1'b0, 1'b1, 1'b1, 16'h0021, 32'h0);
    @(negedge clk_i);
    check("b2b_mem_byt", mem_byt_o, 1'b1);
    check("b2b_mem_sgn", mem_sgn_o, 1'b1);
    check("b2b_mem_addr_b", mem_addr_o, 16'h0021);
    rq_vld_i = '0;
    repeat (4) @(negedge clk_i);
    check("b2b_word_vld", rd_vld_o, 1'b1);
    check("b2b_word_id", rd_id_o, 2'd0);
    check("b2b_word_data", rd_data_o, 32'hDEADBEEF);
    @(negedge clk_i);
    check("b2b_byte_vld", rd_vld_o, 1'b1);
    check("b2b_byte_data", rd_data_o, 32'hFFFFFFBE);
    @(negedge clk_i);
    check("b2b_end_vld", rd_vld_o, 1'b0);

    // Lock held past LOCK_MAX: 16 grants to port 2, then round robin.
    do_reset();
    for (int n = 0; n < REQ_N; n++) set_port(n, 1'b0, 1'b0, 1'b0, 16'h0080 + 16'(n*4), 32'h0);
    rq_vld_i = 4'b0010;
    #1 check("lk_pre", rq_rdy_o, 4'b0010);
    @(negedge clk_i);
    rq_lock_i[2] = 1'b1;
    rq_vld_i = 4'hF;
    for (int i = 0; i < LOCK_MAX; i++) begin
      #1 check("lk_hold", rq_rdy_o, 4'b0100);
      @(negedge clk_i);
    end
    post_lk = '{4'b1000, 4'b0001, 4'b0010, 4'b0100};
    for (int i = 0; i < 4; i++) begin
      #1 check("lk_after", rq_rdy_o, post_lk[i]);
      @(negedge clk_i);
    end

    // Lock dropped after 3 grants; owner idle while locked blocks others.
    do_reset();
    rq_vld_i = 4'b0010;
    #1 check("ld_pre", rq_rdy_o, 4'b0010);
    @(negedge clk_i);
    rq_lock_i[2] = 1'b1;
    rq_vld_i = 4'hF;
    #1 check("ld_g1", rq_rdy_o, 4'b0100);
    @(negedge clk_i);
    #1 check("ld_g2", rq_rdy_o, 4'b0100);
    @(negedge clk_i);
    rq_vld_i = 4'b1011;
    #1 check("ld_owner_idle", rq_rdy_o, 4'b0000);
    @(negedge clk_i);
    rq_vld_i = 4'hF;
    #1 check("ld_g3", rq_rdy_o, 4'b0100);
    @(negedge clk_i);
    rq_lock_i[2] = 1'b0;
    #1 check("ld_release", rq_rdy_o, 4'b1000);
    @(negedge clk_i);
    #1 check("ld_next", rq_rdy_o, 4'b0001);
    @(negedge clk_i);

    // Mixed reads/writes: returns for ports 3,1,0 at c=6,8,10.
    do_reset();
    set_port(3, 1'b0, 1'b0, 1'b0, 16'h0030, 32'h0);
    set_port(2, 1'b1, 1'b0, 1'b0, 16'h0034, 32'h11223344);
    set_port(1, 1'b0, 1'b0, 1'b0, 16'h0038, 32'h0);
    set_port(0, 1'b1, 1'b0, 1'b0, 16'h003C, 32'h55667788);
    for (int c = 0; c < 12; c++) begin
      exp_rv = (c == 6) || (c == 8) || (c == 10);
      check("mix_rd_vld", rd_vld_o, exp_rv);
      if (exp_rv) check("mix_rd_id", rd_id_o, (c == 6) ? 2'd3 : ((c == 8) ? 2'd1 : 2'd0));
      case (c)
        0: rq_vld_i = 4'b1000;
        1: rq_vld_i = 4'b0100;
        2: rq_vld_i = 4'b0010;
        3: rq_vld_i = 4'b0001;
        4: begin rq_vld_i = 4'b0001; rq_wr_i[0] = 1'b0; end
        default: rq_vld_i = 4'b0000;
      endcase
      #1 check("mix_rdy", rq_rdy_o, rq_vld_i);
      @(negedge clk_i);
    end

    // Reset while two reads are in flight: no returns, pointer back to 0.
    do_reset();
    set_port(0, 1'b0, 1'b0, 1'b0, 16'h0044, 32'h0);
    set_port(1, 1'b0, 1'b0, 1'b0, 16'h0048, 32'h0);
    rq_vld_i = 4'b0001;
    #1 check("mf_rdy0", rq_rdy_o, 4'b0001);
    @(negedge clk_i);
    rq_vld_i = 4'b0010;
    #1 check("mf_rdy1", rq_rdy_o, 4'b0010);
    @(negedge clk_i);
    rq_vld_i = '0;
    @(negedge clk_i);
    rst_i = 1'b1;
    #1 check("mf_rst_addr", mem_addr_o, 16'h0000);
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      check("mf_no_return", rd_vld_o, 1'b0);
    end
    rq_vld_i = 4'hF;
    #1 check("mf_ptr0", rq_rdy_o, 4'b0001);
    @(negedge clk_i);
    rq_vld_i = '0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule

// File: doc/hive_mem_arb.md
Name: hive_mem_arb

Overview:
- Arbitrates the main-memory data port among REQ_N requesters (core load/store, debug host, boot loader, DMA), issuing at most one access per clock.
- Uses a round-robin grant with an optional bounded lock for read-modify-write sequences.
- Tracks in-flight reads through a fixed-latency tag pipe and returns each read word to the requester that issued it.
- Sits between the requesters and the memory data port; drives that port's ctl/address/write-data inputs and consumes its read data.

Parameters:
REQ_N, 4, number of requesters (2..8)
MEM_ADDR_W, 16, byte address width
ALU_W, 32, data width
RD_LAT, 4, memory clocks from command sample to read data valid
LOCK_MAX, 16, max consecutive grants held by a locked requester

Ports:
clk_i  in  1  clock
rst_i  in  1  async reset, active high
rq_vld_i  in  REQ_N  request valid, one bit per requester
rq_rdy_o  out  REQ_N  request accepted this cycle (one-hot or zero)
rq_wr_i  in  REQ_N  1=write, 0=read
rq_byt_i  in  REQ_N  byte access
rq_hlf_i  in  REQ_N  halfword access
rq_sgn_i  in  REQ_N  sign-extend read
rq_lock_i  in  REQ_N  hold grant while asserted
rq_addr_i  in  REQ_N*MEM_ADDR_W  byte addresses, packed, requester n at [n*MEM_ADDR_W +: MEM_ADDR_W]
rq_data_i  in  REQ_N*ALU_W  write data, packed likewise
rd_vld_o  out  1  read return valid
rd_id_o  out  $clog2(REQ_N)  requester id of returned read
rd_data_o  out  ALU_W  returned read data
mem_wr_o, mem_byt_o, mem_hlf_o, mem_sgn_o  out  1 each  memory ctl (lit always 0)
mem_addr_o  out  MEM_ADDR_W  memory address (offset tied 0 externally)
mem_data_o  out  ALU_W  memory write data
mem_rd_i  in  ALU_W  memory read data

Behaviour:
- Reset: all outputs 0; rr pointer=0 (port 0 highest priority); lock state idle, lock counter 0; tag pipe cleared. Reads in flight at reset are discarded and never returned.
- Grant is combinational and round-robin. Search starts at pointer p and wraps modulo REQ_N. rq_rdy_o[g]=1 only for the first n with rq_vld_i[n]. Accept = vld&rdy.
- On accept of g, p <= (g+1) mod REQ_N at the same edge. No valid requests -> no grant, p unchanged.
- Lock FSM, states IDLE and LOCKED:
  - IDLE->LOCKED on accept of g with rq_lock_i[g]=1; the owner is latched and cnt=1.
  - In LOCKED, only the owner may be granted. Each owner accept increments cnt. Other requesters get rdy=0 even when the owner is idle.
  - LOCKED->IDLE when rq_lock_i[owner]=0, or on the accept that makes cnt==LOCK_MAX. The forced release sets p=owner+1. The owner cannot re-lock on that accepting edge and must wait one grant cycle.
- Command register: on accept, the mem_* outputs load the granted fields at that edge. With no accept, mem_wr_o<=0 and the remaining mem_* outputs hold their values, so an idle read is harmless.
- Tag pipe: depth RD_LAT+1, entry {vld, id}.
  - Loaded with {accept & ~wr, g} on every edge and shifted each clock.
  - rd_vld_o/rd_id_o come from the last stage; rd_data_o=mem_rd_i (combinational pass-through).
  - Read latency is exactly RD_LAT+1 clocks from the accepting edge to the cycle where rd_vld_o=1. With RD_LAT=4, accept at edge k gives data during the cycle after edge k+5.
- Throughput: one access per clock, back-to-back mixed read/write, no bubbles. Returns stay in order.
- Writes produce no return; accept = committed.
- Width/alignment is passed through unchanged; the memory handles unaligned access.
- rq_* inputs other than vld are don't-care when vld=0.

Test Plan:
- Reset: rst_i=1 with port1 read pending -> all outputs 0. Release, port1 vld addr 0x0010 -> rdy_o=0010, mem_addr_o=0x0010 next cycle, rd_vld_o with id=1 five clocks after accept.
- Round-robin: all 4 ports vld continuously -> grant order 0,1,2,3,0,1. A port idle for one cycle is skipped with no bubble.
- Back-to-back: port0 write 0xDEADBEEF @0x0020, then port0 word read @0x0020 next cycle -> rd_data_o=0xDEADBEEF; byte read @0x0021 sgn=1 -> 0xFFFFFFBE.
- Lock: port2 lock=1, vld held 20 cycles, others vld -> exactly 16 consecutive port2 grants, then port3 granted. Lock dropped after 3 grants -> release, p=3.
- Mixed returns: reads from ports 3,1,0 interleaved with writes -> rd_vld_o pulses with ids 3,1,0 in order, each exactly 5 clocks after its accept, no pulses for writes.
- Reset mid-flight: rst_i asserted 2 clocks after two reads accepted -> no rd_vld_o after reset release, p=0.
